// File: rtl/cond_pkg.sv
// Shared types for the dual input conditioner: debounce FSM state encoding
// and a small state classification helper.
package cond_pkg;

   typedef enum logic [1:0] {
      IDLE_LOW  = 2'd0,
      WAIT_HIGH = 2'd1,
      IDLE_HIGH = 2'd2,
      WAIT_LOW  = 2'd3
   } deb_state_t;

   function automatic logic is_idle(input deb_state_t st);
      return (st == IDLE_LOW) || (st == IDLE_HIGH);
   endfunction

endpackage

// File: rtl/debounce_ch.sv
// One conditioning channel: S-stage synchronizer followed by a debounce FSM
// that accepts a new level only after D consecutive agreeing samples.
module debounce_ch
   import cond_pkg::*;
#(
   parameter int S = 2,
   parameter int D = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall,
   output logic idle
);

   localparam int CNT_W = $clog2(D + 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(D - 1);

   logic [S-1:0]     sync_q;
   logic             sync_s;
   deb_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   assign sync_s = sync_q[S-1];

   // synchronizer chain: raw enters bit 0, the FSM only ever sees the last stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {S{1'b0}};
      end else begin
         sync_q <= {sync_q[S-2:0], raw};
      end
   end

   // FSM, counter and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE_LOW;
         cnt_q   <= CNT_ZERO;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   // next-state logic; CNT_LAST==0 (D=1) accepts straight from the idle state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         IDLE_LOW: begin
            if (sync_s && (CNT_LAST == CNT_ZERO)) begin
               state_d = IDLE_HIGH;
               level_d = 1'b1;
               rise_d  = 1'b1;
               cnt_d   = CNT_ZERO;
            end else if (sync_s) begin
               state_d = WAIT_HIGH;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = CNT_ZERO;
            end
         end
         WAIT_HIGH: begin
            if (!sync_s) begin
               state_d = IDLE_LOW;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE_HIGH;
               level_d = 1'b1;
               rise_d  = 1'b1;
               cnt_d   = CNT_ZERO;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         IDLE_HIGH: begin
            if (!sync_s && (CNT_LAST == CNT_ZERO)) begin
               state_d = IDLE_LOW;
               level_d = 1'b0;
               fall_d  = 1'b1;
               cnt_d   = CNT_ZERO;
            end else if (!sync_s) begin
               state_d = WAIT_LOW;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = CNT_ZERO;
            end
         end
         WAIT_LOW: begin
            if (sync_s) begin
               state_d = IDLE_HIGH;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE_LOW;
               level_d = 1'b0;
               fall_d  = 1'b1;
               cnt_d   = CNT_ZERO;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE_LOW;
            cnt_d   = CNT_ZERO;
            level_d = 1'b0;
         end
      endcase
   end

   assign level = level_q;
   assign rise  = rise_q;
   assign fall  = fall_q;
   assign idle  = is_idle(state_q);

endmodule

// File: rtl/dual_input_conditioner.sv
// Two independent debounced switch inputs feeding and_gate, plus edge pulses
// and a flag that is high while neither channel is qualifying a change.
module dual_input_conditioner
   import cond_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_a,
   input  logic raw_b,
   output logic a,
   output logic b,
   output logic a_rise,
   output logic a_fall,
   output logic b_rise,
   output logic b_fall,
   output logic stable
);

   logic idle_a_s;
   logic idle_b_s;

   debounce_ch #(
      .S (SYNC_STAGES),
      .D (DEBOUNCE_CYCLES)
   ) u_deb_a (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw_a),
      .level (a),
      .rise  (a_rise),
      .fall  (a_fall),
      .idle  (idle_a_s)
   );

   debounce_ch #(
      .S (SYNC_STAGES),
      .D (DEBOUNCE_CYCLES)
   ) u_deb_b (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw_b),
      .level (b),
      .rise  (b_rise),
      .fall  (b_fall),
      .idle  (idle_b_s)
   );

   assign stable = idle_a_s & idle_b_s;

endmodule
